// File: rtl/ddr_arbiter.sv
// ddr_arbiter: shares one DDR3 Avalon-style port between download
// writes, video burst reads and cache burst reads under fixed priority.
module ddr_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int CACHE_BURST = 4,
  parameter int VIDEO_BURST = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  download_wr,
  input  logic [ADDR_WIDTH-1:0] download_addr,
  input  logic [DATA_WIDTH-1:0] download_din,
  input  logic [7:0]            download_mask,
  output logic                  download_waitReq,
  input  logic                  video_rd,
  input  logic [ADDR_WIDTH-1:0] video_addr,
  output logic                  video_waitReq,
  output logic                  video_valid,
  output logic [DATA_WIDTH-1:0] video_dout,
  input  logic                  cache_rd,
  input  logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_waitReq,
  output logic                  cache_valid,
  output logic [DATA_WIDTH-1:0] cache_dout,
  output logic                  cache_burstDone,
  output logic                  ddr_rd,
  output logic                  ddr_wr,
  output logic [ADDR_WIDTH-1:0] ddr_addr,
  output logic [7:0]            ddr_burstCount,
  output logic [7:0]            ddr_mask,
  output logic [DATA_WIDTH-1:0] ddr_din,
  input  logic [DATA_WIDTH-1:0] ddr_dout,
  input  logic                  ddr_waitReq,
  input  logic                  ddr_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_VIDEO_CMD,
    S_VIDEO_DATA,
    S_CACHE_CMD,
    S_CACHE_DATA
  } state_t;

  localparam logic [7:0] LP_VB = 8'(VIDEO_BURST);
  localparam logic [7:0] LP_CB = 8'(CACHE_BURST);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic [7:0]            r_mask;
  logic [7:0]            r_beat;
  logic                  w_clr;
  logic                  w_inc;

  // Next-state, command drive, handshake and beat routing.
  always_comb begin
    w_next           = r_state;
    ddr_rd           = 1'b0;
    ddr_wr           = 1'b0;
    ddr_burstCount   = 8'd1;
    download_waitReq = 1'b1;
    video_waitReq    = 1'b1;
    cache_waitReq    = 1'b1;
    video_valid      = 1'b0;
    cache_valid      = 1'b0;
    cache_burstDone  = 1'b0;
    w_clr            = 1'b0;
    w_inc            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (download_wr)
          w_next = S_WRITE;
        else if (video_rd)
          w_next = S_VIDEO_CMD;
        else if (cache_rd)
          w_next = S_CACHE_CMD;
      end
      S_WRITE: begin
        ddr_wr = 1'b1;
        if (!ddr_waitReq) begin
          download_waitReq = 1'b0;
          w_next           = S_IDLE;
        end
      end
      S_VIDEO_CMD: begin
        ddr_rd         = 1'b1;
        ddr_burstCount = LP_VB;
        if (!ddr_waitReq) begin
          video_waitReq = 1'b0;
          w_clr         = 1'b1;
          w_next        = S_VIDEO_DATA;
        end
      end
      S_VIDEO_DATA: begin
        video_valid = ddr_valid;
        if (ddr_valid) begin
          w_inc = 1'b1;
          if (r_beat == LP_VB - 8'd1)
            w_next = S_IDLE;
        end
      end
      S_CACHE_CMD: begin
        ddr_rd         = 1'b1;
        ddr_burstCount = LP_CB;
        if (!ddr_waitReq) begin
          cache_waitReq = 1'b0;
          w_clr         = 1'b1;
          w_next        = S_CACHE_DATA;
        end
      end
      S_CACHE_DATA: begin
        cache_valid = ddr_valid;
        if (ddr_valid) begin
          w_inc = 1'b1;
          if (r_beat == LP_CB - 8'd1) begin
            cache_burstDone = 1'b1;
            w_next          = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, latched command fields and beat counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_din   <= '0;
      r_mask  <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        if (download_wr) begin
          r_addr <= download_addr;
          r_din  <= download_din;
          r_mask <= download_mask;
        end else if (video_rd) begin
          r_addr <= video_addr;
          r_din  <= '0;
          r_mask <= '0;
        end else if (cache_rd) begin
          r_addr <= cache_addr;
          r_din  <= '0;
          r_mask <= '0;
        end
      end
      if (w_clr)
        r_beat <= '0;
      else if (w_inc)
        r_beat <= r_beat + 8'd1;
    end
  end

  assign ddr_addr   = r_addr;
  assign ddr_din    = r_din;
  assign ddr_mask   = r_mask;
  assign video_dout = ddr_dout;
  assign cache_dout = ddr_dout;

endmodule

// File: doc/ddr_arbiter.md
Name: ddr_arbiter

Overview:
- Shares the single DDR3 Avalon-style port between three requesters: ROM download writes, video frame DMA reads and CPU/tile cache reads.
- Sits between the Main core's requesters and the top-level ddr3_*_arbiter nets.
- Serialises requests under fixed priority, holds each command until the DDR accepts it, and routes read beats back only to the granted requester.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 64, data width on all ports.
- CACHE_BURST, 4, beats per cache read (1..255).
- VIDEO_BURST, 16, beats per video read (1..255).

Ports:
- clock  in  1  system clock (100 MHz domain).
- reset  in  1  synchronous, active-high reset.
- download_wr  in  1  write request, held until accepted.
- download_addr  in  ADDR_WIDTH  write byte address.
- download_din  in  DATA_WIDTH  write data.
- download_mask  in  8  byte enables.
- download_waitReq  out  1  low for exactly the cycle the write is accepted.
- video_rd  in  1  burst read request, held until accepted.
- video_addr  in  ADDR_WIDTH  burst start address.
- video_waitReq  out  1  low for the single acceptance cycle.
- video_valid  out  1  read beat strobe.
- video_dout  out  DATA_WIDTH  read beat data.
- cache_rd  in  1  burst read request.
- cache_addr  in  ADDR_WIDTH  burst start address.
- cache_waitReq  out  1  low for the single acceptance cycle.
- cache_valid  out  1  read beat strobe.
- cache_dout  out  DATA_WIDTH  read beat data.
- cache_burstDone  out  1  one-cycle pulse with the last cache beat.
- ddr_rd  out  1  read command.
- ddr_wr  out  1  write command.
- ddr_addr  out  ADDR_WIDTH  command address.
- ddr_burstCount  out  8  beats in this command.
- ddr_mask  out  8  write byte enables.
- ddr_din  out  DATA_WIDTH  write data.
- ddr_dout  in  DATA_WIDTH  read data.
- ddr_waitReq  in  1  command stall.
- ddr_valid  in  1  read data valid.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- States: IDLE, WRITE, VIDEO_CMD, VIDEO_DATA, CACHE_CMD, CACHE_DATA. Reset forces IDLE.
- Reset values: ddr_rd=0, ddr_wr=0, all *_valid=0, cache_burstDone=0, all *_waitReq=1, ddr_burstCount=1, ddr_addr/din/mask=0.
- IDLE arbitration, fixed priority download_wr > video_rd > cache_rd:
  - The winner's address, data and mask are latched into registers.
  - Next state is WRITE, VIDEO_CMD or CACHE_CMD.
  - No command is issued in the IDLE cycle itself.
- WRITE:
  - ddr_wr=1 and burstCount=1, driven from the latched registers.
  - Accept = ddr_wr & ~ddr_waitReq. On accept: download_waitReq=0 for that cycle, then IDLE.
- VIDEO_CMD / CACHE_CMD:
  - ddr_rd=1, burstCount=VIDEO_BURST or CACHE_BURST.
  - Held stable while ddr_waitReq=1.
  - On accept: that requester's waitReq=0 for one cycle, beat counter cleared, go to *_DATA.
- *_DATA:
  - Each ddr_valid drives owner_valid=ddr_valid combinationally, owner_dout=ddr_dout, and increments an 8-bit beat counter.
  - Beat = burst-1 ends the burst: go to IDLE; for cache, cache_burstDone pulses with that beat.
  - The non-owner's valid stays 0.
  - Read latency from ddr_valid to owner_valid is 0 cycles.
- Back-to-back requests: at least one IDLE cycle between transactions. A request asserted during another transaction is granted in the next IDLE cycle.
- Simultaneous requests: the higher priority wins. A losing requester keeps its request held and is served once no higher request is pending.
- Starvation: the video requester bounds its own rate (FIFO threshold) and cache starvation is accepted. Download writes only occur while the core is held in reset.
- Requester protocol: a requester must hold rd/wr and its address stable until its waitReq goes low.
- Edge cases:
  - Dropping a request before acceptance is illegal; behaviour is undefined.
  - ddr_valid in IDLE, WRITE or *_CMD is a stray beat: it is dropped and no client valid asserts.
  - Reset mid-burst returns to IDLE; remaining DDR beats are dropped as stray.
  - ddr_waitReq=1 in *_DATA has no effect on beat capture.

Test Plan:
- Single write of addr=0x100, din=0x1122334455667788, mask=0xFF with waitReq low → ddr_wr high 1 cycle with the same fields and burstCount=1; download_waitReq low in that same cycle.
- Video read of addr=0x2000 with ddr_waitReq held 3 cycles → ddr_rd stable for 4 cycles and burstCount=16; 16 ddr_valid beats with a gap every 3rd → 16 video_valid pulses carrying matching data; cache_valid stays 0.
- download_wr, video_rd and cache_rd all raised in the same cycle → served in order write, video, cache, each separated by ≥1 IDLE cycle.
- Cache read of CACHE_BURST=4 beats → cache_burstDone pulses with beat 4 only; next cache_rd granted afterwards.
- Reset asserted after the 5th of 16 video beats → outputs return to reset values next cycle; 11 further ddr_valid beats produce no video_valid or cache_valid.
- ddr_valid pulse injected in IDLE → no client valid asserted; a subsequent cache burst completes normally with 4 beats.
